// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: pipelined add/subtract unit with a segmented carry chain.
//
// The WIDTH-bit carry chain is cut into SEGMENTS registered pieces of
// SEG_W = ceil(WIDTH/SEGMENTS) bits (the last piece takes the remainder), so
// one operation is accepted per ce-enabled cycle. Stage 0 registers the
// operands; stage k (1..SEGMENTS) adds segment k-1 using the carry registered
// by stage k-1. Latency is SEGMENTS+1 ce-enabled cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears valids, sum and out_valid
//   ce         pipeline advance enable; 0 holds every register
//   in_valid   a/b/sub qualify this cycle
//   a, b       unsigned operands, WIDTH bits
//   sub        0: a+b, 1: a-b (sum[WIDTH] = 1 means no borrow)
//   out_valid  sum holds a completed result
//   sum        WIDTH+1 bit result, bit WIDTH is the carry out
//   ovf        (only with ADDER_PIPE_OVF_EN) signed overflow, aligned with sum
//
// Optional feature macro: ADDER_PIPE_OVF_EN adds the ovf output.

module adder_pipe_seg #(
    parameter int WIDTH    = 62,
    parameter int SEGMENTS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH:0]   sum
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SEG_W = (WIDTH + SEGMENTS - 1) / SEGMENTS;

    // Stage 0: raw operand capture. Data is captured every ce cycle; only
    // the valid bit says whether it means anything.
    logic [WIDTH-1:0] s0_a_d, s0_a_q;
    logic [WIDTH-1:0] s0_b_d, s0_b_q;
    logic             s0_sub_d, s0_sub_q;
    logic             s0_valid_d, s0_valid_q;

    always_comb begin
        s0_a_d     = a;
        s0_b_d     = b;
        s0_sub_d   = sub;
        s0_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_sub_q   <= 1'b0;
            s0_valid_q <= 1'b0;
        end else if (ce) begin
            s0_a_q     <= s0_a_d;
            s0_b_q     <= s0_b_d;
            s0_sub_q   <= s0_sub_d;
            s0_valid_q <= s0_valid_d;
        end
    end

    // Stage k adds bits [HI-1:LO]. Each stage keeps only what is still
    // needed: the finished low result bits [HI-1:0] plus the not-yet-added
    // operand bits [WIDTH-1:HI]. When SEGMENTS does not divide WIDTH evenly
    // trailing stages may be empty (LO >= WIDTH); they are pure delay.
    for (genvar k = 1; k <= SEGMENTS; k++) begin : g_stage
        localparam int LO = (k - 1) * SEG_W;
        localparam int HI = (k * SEG_W > WIDTH) ? WIDTH : k * SEG_W;

        logic          valid_in;
        logic          carry_in;
        logic          valid_d, valid_q;
        logic          carry_d, carry_q;
        logic [HI-1:0] res_d, res_q;

        if (k == 1) begin : g_src
            // Subtraction is a + ~b + 1: the +1 enters as the carry-in.
            assign valid_in = s0_valid_q;
            assign carry_in = s0_sub_q;
        end else begin : g_src
            assign valid_in = g_stage[k-1].valid_q;
            assign carry_in = g_stage[k-1].carry_q;
        end

        always_comb begin
            valid_d = valid_in;
        end

        if (LO < WIDTH) begin : g_add
            logic [WIDTH-1:LO] a_in;
            logic [WIDTH-1:LO] b_in;
            logic [HI-1:LO]    seg;

            if (k == 1) begin : g_opnd
                // B' is formed once here and carried forward already inverted.
                assign a_in = s0_a_q;
                assign b_in = s0_sub_q ? ~s0_b_q : s0_b_q;
            end else begin : g_opnd
                assign a_in = g_stage[k-1].g_add.g_fwd.a_q;
                assign b_in = g_stage[k-1].g_add.g_fwd.b_q;
            end

            always_comb begin
                {carry_d, seg} = {1'b0, a_in[HI-1:LO]}
                               + {1'b0, b_in[HI-1:LO]}
                               + {{(HI-LO){1'b0}}, carry_in};
            end

            if (k == 1) begin : g_res
                assign res_d = seg;
            end else begin : g_res
                assign res_d = {seg, g_stage[k-1].res_q};
            end

            if (HI < WIDTH) begin : g_fwd
                logic [WIDTH-1:HI] a_d, a_q;
                logic [WIDTH-1:HI] b_d, b_q;

                always_comb begin
                    a_d = a_in[WIDTH-1:HI];
                    b_d = b_in[WIDTH-1:HI];
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (ce) begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end
            end
        end else begin : g_pass
            always_comb begin
                res_d   = g_stage[k-1].res_q;
                carry_d = carry_in;
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        if (HI == WIDTH) begin : g_ovf
            logic ovf_d, ovf_q;

            if (LO < WIDTH) begin : g_calc
                // Carry into the MSB is recovered from its sum bit:
                // s = a ^ b' ^ c_in, so c_in = a ^ b' ^ s.
                assign ovf_d = g_add.a_in[WIDTH-1] ^ g_add.b_in[WIDTH-1]
                             ^ res_d[WIDTH-1] ^ carry_d;
            end else begin : g_calc
                assign ovf_d = g_stage[k-1].g_ovf.ovf_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (ce) begin
                    ovf_q <= ovf_d;
                end
            end
        end
`endif

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else if (ce) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end
    end

    assign out_valid = g_stage[SEGMENTS].valid_q;
    assign sum       = {g_stage[SEGMENTS].carry_q, g_stage[SEGMENTS].res_q};
`ifdef ADDER_PIPE_OVF_EN
    assign ovf       = g_stage[SEGMENTS].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Testbench for adder_pipe_seg (WIDTH=62, SEGMENTS=4), plus an 8-bit,
// 2-segment instance exercising ovf when ADDER_PIPE_OVF_EN is defined.

module tb_adder_pipe_seg;

    localparam int W = 62;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         ce;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic [W:0]   sum;

    always #5 clk = ~clk;

`ifdef ADDER_PIPE_OVF_EN
    logic       ovf;
    logic       ce8;
    logic       in_valid8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       sub8;
    logic       out_valid8;
    logic [8:0] sum8;
    logic       ovf8;
`endif

    adder_pipe_seg #(.WIDTH(W), .SEGMENTS(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .sum       (sum)
`ifdef ADDER_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifdef ADDER_PIPE_OVF_EN
    adder_pipe_seg #(.WIDTH(8), .SEGMENTS(2)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce8),
        .in_valid  (in_valid8),
        .a         (a8),
        .b         (b8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .sum       (sum8),
        .ovf       (ovf8)
    );
`endif

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference pipeline: entry 0 is the input register, entry S the output.
    logic         m_v [0:S];
    logic [W:0]   m_s [0:S];

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic [W-1:0] d;
        d = x - y;
        if (s) return {(x >= y), d};
        return {1'b0, x} + {1'b0, y};
    endfunction

    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cev, input logic rv);
        in_valid = v;
        a        = av;
        b        = bv;
        sub      = sv;
        ce       = cev;
        reset    = rv;
        @(posedge clk);
        if (rv) begin
            for (int i = 0; i <= S; i++) begin
                m_v[i] = 1'b0;
                m_s[i] = '0;
            end
        end else if (cev) begin
            for (int i = S; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_s[i] = m_s[i-1];
            end
            m_v[0] = v;
            m_s[0] = ref_sum(av, bv, sv);
        end
        #1;
        check("out_valid", {63'd0, out_valid}, {63'd0, m_v[S]});
        if (m_v[S]) check("sum", {1'b0, sum}, {1'b0, m_s[S]});
    endtask

    task automatic bubble();
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    localparam int ND = 8;
    logic [W-1:0] va   [ND];
    logic [W-1:0] vb   [ND];
    logic         vs   [ND];
    logic [W:0]   vexp [ND];

    initial begin
        logic         rv;
        logic [W-1:0] ra, rb;
        int           n;

        for (int i = 0; i <= S; i++) begin
            m_v[i] = 1'b0;
            m_s[i] = '0;
        end
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; ce = 1'b1; reset = 1'b1;
`ifdef ADDER_PIPE_OVF_EN
        ce8 = 1'b1; in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
`endif

        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("reset_sum", {1'b0, sum}, 64'd0);
`ifdef ADDER_PIPE_OVF_EN
        check("reset_ovf", {63'd0, ovf}, 64'd0);
`endif

        // Directed vectors, issued back to back; each emerges 5 steps later.
        va = '{62'h3FFF_FFFF_FFFF_FFFF, 62'd5, 62'd7, 62'h3FFF_FFFF_FFFF_FFFF,
               62'd0, 62'h2AAA_AAAA_AAAA_AAAA, 62'h0000_0000_0000_FFFF,
               62'h0000_FFFF_FFFF_FFFF};
        vb = '{62'd1, 62'd7, 62'd5, 62'h3FFF_FFFF_FFFF_FFFF,
               62'd1, 62'h2AAA_AAAA_AAAA_AAAA, 62'd1, 62'd1};
        vs = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vexp = '{63'h4000_0000_0000_0000, 63'h3FFF_FFFF_FFFF_FFFE,
                 63'h4000_0000_0000_0002, 63'h7FFF_FFFF_FFFF_FFFE,
                 63'h3FFF_FFFF_FFFF_FFFF, 63'h4000_0000_0000_0000,
                 63'h0000_0000_0001_0000, 63'h0001_0000_0000_0000};
        for (int i = 0; i < ND + S; i++) begin
            if (i < ND) step(1'b1, va[i], vb[i], vs[i], 1'b1, 1'b0);
            else        bubble();
            if (i >= S) begin
                check($sformatf("directed%0d_valid", i - S), {63'd0, out_valid}, 64'd1);
                check($sformatf("directed%0d_sum", i - S), {1'b0, sum}, {1'b0, vexp[i-S]});
            end
        end
        bubble();
        check("drain_valid", {63'd0, out_valid}, 64'd0);

        // Random stream with gaps and a 3-cycle ce hold in the middle.
        n = 0;
        while (n < 100) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            step(rv, ra, rb, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            if (rv) n++;
            if (n == 50 && rv) begin
                for (int h = 0; h < 3; h++)
                    step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
            end
        end
        repeat (S + 1) bubble();

        // Reset with 4 operations in flight; nothing stale may emerge.
        for (int i = 0; i < 4; i++) step(1'b1, 62'd1000 + 62'(i), 62'd1, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_sum", {1'b0, sum}, 64'd0);
        step(1'b1, 62'd100, 62'd23, 1'b0, 1'b1, 1'b0);
        repeat (S) bubble();
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        check("post_rst_sum", {1'b0, sum}, 64'd123);

`ifdef ADDER_PIPE_OVF_EN
        in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0;
        bubble();
        a8 = 8'h80; b8 = 8'h01; sub8 = 1'b1;
        bubble();
        a8 = 8'h03; b8 = 8'h04; sub8 = 1'b0;
        bubble();
        in_valid8 = 1'b0;
        check("ovf8_op1_valid", {63'd0, out_valid8}, 64'd1);
        check("ovf8_op1_sum", {55'd0, sum8}, 64'h080);
        check("ovf8_op1_ovf", {63'd0, ovf8}, 64'd1);
        bubble();
        check("ovf8_op2_sum", {55'd0, sum8}, 64'h17F);
        check("ovf8_op2_ovf", {63'd0, ovf8}, 64'd1);
        bubble();
        check("ovf8_op3_sum", {55'd0, sum8}, 64'h007);
        check("ovf8_op3_ovf", {63'd0, ovf8}, 64'd0);
        bubble();
        check("ovf8_drain_valid", {63'd0, out_valid8}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
